fire_command_sequencer: RTL and testbench

- Sits directly downstream of the trigger authorizer and consumes its 1-cycle enable_fire pulse.
- Requires a human operator confirmation within a bounded window, then drives the firing actuator over a req/ack handshake.
- Tracks remaining rounds, enforces a post-shot cooldown, and latches a sticky fault on actuator protocol errors.
- It is the only block allowed to drive the actuator request line.

---
 rtl/fire_seq_pkg.sv | 24 ++
 rtl/fire_seq_timer.sv | 26 ++
 rtl/fire_command_sequencer.sv | 152 +++++++++++++++
 tb/tb_fire_command_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fire_seq_pkg.sv
// Shared definitions for the fire command sequencer: state encoding (also
// consumed by the telemetry logger) and default timing constants.
package fire_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARMED    = 3'd1,
    ST_FIRING   = 3'd2,
    ST_COOLDOWN = 3'd3,
    ST_FAULT    = 3'd4
  } fire_state_e;

  localparam int DEF_CONFIRM_WINDOW = 16;
  localparam int DEF_ACK_TIMEOUT    = 32;
  localparam int DEF_COOLDOWN       = 64;
  localparam int DEF_MAG_CAPACITY   = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/fire_seq_timer.sv
// Loadable down-counter shared by all timed states of the fire sequencer.
module fire_seq_timer #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/fire_command_sequencer.sv
// Operator-confirmed fire sequencer: arms on an authorization pulse, drives the
// actuator req/ack handshake, tracks the magazine and latches protocol faults.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for enable_fire; reload accepted
// ARMED    | confirm window open, timer counts the remaining window
// FIRING   | act_req high, timer counts the remaining ack budget
// COOLDOWN | post-shot hold-off, timer counts the remaining cooldown
// FAULT    | sticky fault; needs fault_clear with act_ack low
module fire_command_sequencer
  import fire_seq_pkg::*;
#(
  parameter int CONFIRM_WINDOW = DEF_CONFIRM_WINDOW,
  parameter int ACK_TIMEOUT    = DEF_ACK_TIMEOUT,
  parameter int COOLDOWN       = DEF_COOLDOWN,
  parameter int MAG_CAPACITY   = DEF_MAG_CAPACITY,
  localparam int RW            = $clog2(MAG_CAPACITY + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable_fire,
  input  logic          operator_confirm,
  input  logic          manual_lock,
  input  logic          abort_req,
  output logic          act_req,
  input  logic          act_ack,
  input  logic          reload,
  input  logic          fault_clear,
  output logic [RW-1:0] rounds_left,
  output logic          busy,
  output logic          fault,
  output logic [2:0]    seq_state
);

  localparam logic [2:0] S_IDLE     = ST_IDLE;
  localparam logic [2:0] S_ARMED    = ST_ARMED;
  localparam logic [2:0] S_FIRING   = ST_FIRING;
  localparam logic [2:0] S_COOLDOWN = ST_COOLDOWN;
  localparam logic [2:0] S_FAULT    = ST_FAULT;

  localparam int TMAX = max3(CONFIRM_WINDOW, ACK_TIMEOUT, COOLDOWN);
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0] T_CONFIRM  = TW'(CONFIRM_WINDOW - 1);
  localparam logic [TW-1:0] T_ACK      = TW'(ACK_TIMEOUT - 1);
  localparam logic [TW-1:0] T_COOLDOWN = TW'(COOLDOWN - 1);
  localparam logic [RW-1:0] FULL_MAG   = RW'(MAG_CAPACITY);

  logic [2:0]    state_q, state_nxt;
  logic [RW-1:0] rounds_q, rounds_nxt;
  logic          act_req_q;
  logic          tmr_load, tmr_dec, tmr_zero;
  logic [TW-1:0] tmr_val, tmr_count;

  fire_seq_timer #(
    .WIDTH (TW)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .count    (tmr_count),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_nxt  = state_q;
    rounds_nxt = rounds_q;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    tmr_dec    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (act_ack) begin
          state_nxt = S_FAULT;
        end else begin
          if (reload) rounds_nxt = FULL_MAG;
          if (enable_fire && (rounds_q != '0) && !manual_lock && !abort_req) begin
            state_nxt = S_ARMED;
            tmr_load  = 1'b1;
            tmr_val   = T_CONFIRM;
          end
        end
      end
      S_ARMED: begin
        if (act_ack) begin
          state_nxt = S_FAULT;
        end else if (manual_lock || abort_req) begin
          state_nxt = S_IDLE;
        end else if (operator_confirm) begin
          state_nxt = S_FIRING;
          tmr_load  = 1'b1;
          tmr_val   = T_ACK;
        end else if (tmr_zero) begin
          state_nxt = S_IDLE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      // Lock/abort are deliberately not looked at: req must not drop before ack.
      S_FIRING: begin
        if (act_ack) begin
          state_nxt = S_COOLDOWN;
          tmr_load  = 1'b1;
          tmr_val   = T_COOLDOWN;
          if (rounds_q != '0) rounds_nxt = rounds_q - RW'(1);
        end else if (tmr_zero) begin
          state_nxt = S_FAULT;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      S_COOLDOWN: begin
        if (act_ack) begin
          state_nxt = S_FAULT;
        end else if (tmr_zero) begin
          state_nxt = S_IDLE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      S_FAULT: begin
        if (reload) rounds_nxt = FULL_MAG;
        if (fault_clear && !act_ack) state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_FAULT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rounds_q  <= FULL_MAG;
      act_req_q <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      rounds_q  <= rounds_nxt;
      act_req_q <= (state_nxt == S_FIRING);
    end
  end

  assign act_req     = act_req_q;
  assign rounds_left = rounds_q;
  assign busy        = (state_q != S_IDLE);
  assign fault       = (state_q == S_FAULT);
  assign seq_state   = state_q;

endmodule

// File: tb/tb_fire_command_sequencer.sv
// Bench for fire_command_sequencer: directed scenarios plus random traffic,
// every cycle compared against a deadline-based reference model.
module tb_fire_command_sequencer;

  localparam int CW  = 16;
  localparam int AT  = 32;
  localparam int CD  = 64;
  localparam int CAP = 8;
  localparam int RW  = 4;

  localparam int M_IDLE = 0, M_ARMED = 1, M_FIRING = 2, M_COOLDOWN = 3, M_FAULT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable_fire = 1'b0, operator_confirm = 1'b0, manual_lock = 1'b0, abort_req = 1'b0;
  logic act_ack = 1'b0, reload = 1'b0, fault_clear = 1'b0;
  logic act_req, busy, fault;
  logic [RW-1:0] rounds_left;
  logic [2:0] seq_state;

  int n_tests = 0;
  int n_fail  = 0;
  int m_state, m_rounds, m_last, m_cyc;

  always #5 clk = ~clk;

  fire_command_sequencer dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .enable_fire      (enable_fire),
    .operator_confirm (operator_confirm),
    .manual_lock      (manual_lock),
    .abort_req        (abort_req),
    .act_req          (act_req),
    .act_ack          (act_ack),
    .reload           (reload),
    .fault_clear      (fault_clear),
    .rounds_left      (rounds_left),
    .busy             (busy),
    .fault            (fault),
    .seq_state        (seq_state)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, m_cyc);
    end
  endtask

  task automatic model_reset();
    m_state  = M_IDLE;
    m_rounds = CAP;
    m_last   = 0;
  endtask

  // Deadlines are absolute cycle numbers: m_last is the final cycle of the
  // current timed state.
  task automatic model_update();
    bit arm;
    case (m_state)
      M_IDLE: begin
        if (act_ack) m_state = M_FAULT;
        else begin
          arm = enable_fire && (m_rounds != 0) && !manual_lock && !abort_req;
          if (reload) m_rounds = CAP;
          if (arm) begin
            m_state = M_ARMED;
            m_last  = m_cyc + CW;
          end
        end
      end
      M_ARMED: begin
        if (act_ack) m_state = M_FAULT;
        else if (manual_lock || abort_req) m_state = M_IDLE;
        else if (operator_confirm) begin
          m_state = M_FIRING;
          m_last  = m_cyc + AT;
        end else if (m_cyc == m_last) m_state = M_IDLE;
      end
      M_FIRING: begin
        if (act_ack) begin
          m_state  = M_COOLDOWN;
          m_rounds = m_rounds - 1;
          m_last   = m_cyc + CD;
        end else if (m_cyc == m_last) m_state = M_FAULT;
      end
      M_COOLDOWN: begin
        if (act_ack) m_state = M_FAULT;
        else if (m_cyc == m_last) m_state = M_IDLE;
      end
      default: begin
        if (reload) m_rounds = CAP;
        if (fault_clear && !act_ack) m_state = M_IDLE;
      end
    endcase
    m_cyc++;
  endtask

  task automatic compare_all();
    chk_eq("state", seq_state, m_state);
    chk_eq("act_req", act_req, int'(m_state == M_FIRING));
    chk_eq("rounds", rounds_left, m_rounds);
    chk_eq("busy", busy, int'(m_state != M_IDLE));
    chk_eq("fault", fault, int'(m_state == M_FAULT));
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
    enable_fire      = 1'b0;
    operator_confirm = 1'b0;
    abort_req        = 1'b0;
    act_ack          = 1'b0;
    reload           = 1'b0;
    fault_clear      = 1'b0;
  endtask

  task automatic do_shot();
    enable_fire = 1'b1;      step();
    operator_confirm = 1'b1; step();
    act_ack = 1'b1;          step();
    repeat (CD) step();
  endtask

  initial begin
    m_cyc = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    compare_all();

    // nominal shot: enable at 10, confirm at 13, ack at 16
    repeat (10) step();
    enable_fire = 1'b1; step();
    step(); step();
    operator_confirm = 1'b1; step();
    chk_eq("nom_req_on", act_req, 1);
    step(); step();
    act_ack = 1'b1; step();
    chk_eq("nom_req_off", act_req, 0);
    chk_eq("nom_rounds", rounds_left, 7);
    repeat (CD - 1) step();
    chk_eq("nom_cd_last", seq_state, M_COOLDOWN);
    step();
    chk_eq("nom_idle", seq_state, M_IDLE);

    // confirm window expiry, late confirm ignored
    enable_fire = 1'b1; step();
    repeat (CW - 1) step();
    chk_eq("win_last", seq_state, M_ARMED);
    step();
    chk_eq("win_idle", seq_state, M_IDLE);
    operator_confirm = 1'b1; step();
    chk_eq("win_late_conf", act_req, 0);

    // abort beats confirm in ARMED
    enable_fire = 1'b1; step();
    step();
    abort_req = 1'b1; operator_confirm = 1'b1; step();
    chk_eq("abort_idle", seq_state, M_IDLE);
    chk_eq("abort_noreq", act_req, 0);

    // manual lock during FIRING does not drop req
    enable_fire = 1'b1; step();
    operator_confirm = 1'b1; step();
    manual_lock = 1'b1;
    repeat (5) step();
    chk_eq("lock_req_held", act_req, 1);
    manual_lock = 1'b0;
    act_ack = 1'b1; step();
    chk_eq("lock_cd", seq_state, M_COOLDOWN);
    repeat (CD) step();

    // ack timeout -> FAULT, then clear
    enable_fire = 1'b1; step();
    operator_confirm = 1'b1; step();
    repeat (AT - 1) step();
    chk_eq("to_last_req", act_req, 1);
    step();
    chk_eq("to_fault", fault, 1);
    chk_eq("to_req_off", act_req, 0);
    chk_eq("to_rounds", rounds_left, 6);
    repeat (7) step();
    fault_clear = 1'b1; step();
    chk_eq("to_cleared", seq_state, M_IDLE);

    // ack on the final timeout cycle wins; reload in COOLDOWN ignored
    enable_fire = 1'b1; step();
    operator_confirm = 1'b1; step();
    repeat (AT - 1) step();
    act_ack = 1'b1; step();
    chk_eq("late_ack_cd", seq_state, M_COOLDOWN);
    reload = 1'b1; step();
    chk_eq("cd_reload", rounds_left, 5);
    repeat (CD - 1) step();

    reload = 1'b1; step();
    chk_eq("idle_reload", rounds_left, CAP);

    // empty the magazine
    repeat (CAP) do_shot();
    chk_eq("mag_empty", rounds_left, 0);
    enable_fire = 1'b1; step();
    chk_eq("mag_empty_busy", busy, 0);
    reload = 1'b1; step();
    chk_eq("mag_reload", rounds_left, CAP);

    // spurious ack in IDLE
    act_ack = 1'b1; step();
    chk_eq("spur_fault", fault, 1);
    fault_clear = 1'b1; act_ack = 1'b1; step();
    chk_eq("clear_blocked", fault, 1);
    fault_clear = 1'b1; step();
    chk_eq("clear_ok", fault, 0);

    // reset mid-FIRING
    enable_fire = 1'b1; step();
    operator_confirm = 1'b1; step();
    act_ack = 1'b1; step();
    repeat (CD) step();
    enable_fire = 1'b1; step();
    operator_confirm = 1'b1; step();
    step();
    chk_eq("rst_pre_req", act_req, 1);
    rst_n = 1'b0;
    #1;
    chk_eq("rst_req", act_req, 0);
    chk_eq("rst_rounds", rounds_left, CAP);
    chk_eq("rst_state", seq_state, M_IDLE);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    compare_all();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      enable_fire      = ($urandom_range(0, 3) == 0);
      operator_confirm = ($urandom_range(0, 3) == 0);
      manual_lock      = ($urandom_range(0, 11) == 0);
      abort_req        = ($urandom_range(0, 11) == 0);
      reload           = ($urandom_range(0, 39) == 0);
      fault_clear      = ($urandom_range(0, 3) == 0);
      if (m_state == M_FIRING) act_ack = ($urandom_range(0, 5) == 0);
      else                     act_ack = ($urandom_range(0, 199) == 0);
      step();
    end
    manual_lock = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
